// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, frame length and the
// odd-parity helper used by both host transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAITIDLE
  } tx_state_t;

  // start + 8 data + parity + stop
  localparam int FRAME_LEN = 11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-flop synchronizer, FILTER_CYCLES stability filter and
// a one-cycle falling-edge strobe on the filtered level.
module ps2_line_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic line,
  output logic level,
  output logic fe
);

  localparam int CW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt tracks how many consecutive samples have disagreed with level
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      fe    <= 1'b0;
    end else begin
      sync <= {sync[0], line};
      fe   <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        fe    <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain line enables.
// Optional watchdog on the device-clocked phase: define PS2_TX_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | lines released, ready to accept a byte
// INHIBIT   | clock held low; start bit asserted in the final cycle
// REQ       | clock released, data low; waiting for first device clock
// SHIFT     | data bits, parity, then stop bit driven on device falling edges
// ACK       | sample the device acknowledge on the next falling edge
// WAITIDLE  | wait for both filtered lines to return high
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int          IW       = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [3:0]  PAR_IDX  = 4'(FRAME_LEN - 3);
  localparam logic [3:0]  STOP_IDX = 4'(FRAME_LEN - 2);

  tx_state_t   state, state_n;
  logic [IW-1:0] inh_cnt, inh_n;
  logic [3:0]  bit_idx, bit_n, bit_inc;
  logic [7:0]  data_q;
  logic        par_q, load;
  logic        clk_oe_n, data_oe_n, done_n, err_n;
  logic        idle_q;
  logic        clk_lvl, clk_fe, data_lvl, data_fe_unused;
  logic        active, timeout;

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filt (
    .clk(clk), .rstn(rstn), .line(ps2_clk_in), .level(clk_lvl), .fe(clk_fe)
  );

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filt (
    .clk(clk), .rstn(rstn), .line(ps2_data_in), .level(data_lvl), .fe(data_fe_unused)
  );

  assign active  = (state == ST_REQ) || (state == ST_SHIFT) || (state == ST_ACK);
  assign bit_inc = (bit_idx == 4'hF) ? bit_idx : bit_idx + 4'd1;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;

  // Reloaded throughout INHIBIT so it starts full on REQ entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                         wd_cnt <= '0;
    else if (state == ST_INHIBIT)      wd_cnt <= WW'(TIMEOUT_CYCLES - 1);
    else if (active && wd_cnt != '0)   wd_cnt <= wd_cnt - 1'b1;
  end

  assign timeout = active && (wd_cnt == '0);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    inh_n     = inh_cnt;
    bit_n     = bit_idx;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    err_n     = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (tx_valid) begin
          load     = 1'b1;
          inh_n    = IW'(INHIBIT_CYCLES - 1);
          clk_oe_n = 1'b1;
          state_n  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt == '0) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          bit_n     = 4'd0;
          state_n   = ST_REQ;
        end else begin
          inh_n = inh_cnt - 1'b1;
          if (inh_cnt == IW'(1)) data_oe_n = 1'b1;
        end
      end
      ST_REQ: begin
        if (clk_fe) begin
          bit_n     = bit_inc;
          data_oe_n = ~data_q[0];
          state_n   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (clk_fe) begin
          bit_n = bit_inc;
          if (bit_idx < PAR_IDX) begin
            data_oe_n = ~data_q[bit_idx[2:0]];
          end else if (bit_idx == PAR_IDX) begin
            data_oe_n = ~par_q;
          end else if (bit_idx == STOP_IDX) begin
            data_oe_n = 1'b0;
            state_n   = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (clk_fe) begin
          bit_n   = bit_inc;
          done_n  = ~data_lvl;
          err_n   = data_lvl;
          state_n = ST_WAITIDLE;
        end
      end
      ST_WAITIDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (clk_lvl && data_lvl) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    // Watchdog wins over a coincident device edge.
    if (timeout) begin
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      done_n    = 1'b0;
      err_n     = 1'b1;
      state_n   = ST_WAITIDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      inh_cnt     <= '0;
      bit_idx     <= 4'd0;
      data_q      <= 8'h00;
      par_q       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state       <= state_n;
      inh_cnt     <= inh_n;
      bit_idx     <= bit_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      done        <= done_n;
      err         <= err_n;
      idle_q      <= (state_n == ST_IDLE);
      if (load) begin
        data_q <= tx_data;
        par_q  <= odd_parity(tx_data);
      end
    end
  end

  assign tx_ready = idle_q;
  assign busy     = ~idle_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: device BFM on the open-drain lines and a
// frame model built from the PS/2 host-to-device framing rules.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TO   = 5000;
  localparam int FLT  = 4;
  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] drv_data = 8'h00, noise_data = 8'hAA, tx_data;
  logic       drv_valid = 1'b0, noise_valid = 1'b0, tx_valid;
  logic       tx_ready, busy, done, err;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       bfm_clk = 1'b1, bfm_data = 1'b1, glitch = 1'b1;
  logic       noise_en = 1'b0;
  int         noise_left = 0, glitch_left = 0;

  int vectors = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, frame_cnt = 0, oe_run = 0, last_oe_run = 0;
  logic prev_oe = 1'b0;

  always #5 clk = ~clk;

  assign tx_valid    = drv_valid | noise_valid;
  assign tx_data     = noise_en ? noise_data : drv_data;
  assign ps2_clk_in  = bfm_clk & glitch & ~ps2_clk_oe;
  assign ps2_data_in = bfm_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_CYCLES(FLT)) dut (
    .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .err(err),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (ps2_clk_oe && !prev_oe) frame_cnt++;
    if (ps2_clk_oe) oe_run++;
    else if (oe_run != 0) begin
      last_oe_run = oe_run;
      oe_run = 0;
    end
    prev_oe = ps2_clk_oe;
  end

  // tx_valid chatter and short clock glitches while a frame is in flight
  always @(negedge clk) begin
    if (noise_en && noise_left > 0) begin
      noise_left--;
      noise_valid = 1'($urandom_range(0, 1));
      if (glitch_left > 0) glitch_left--;
      else if ($urandom_range(0, 59) == 0) glitch_left = 2;
      glitch = (glitch_left == 0);
    end else begin
      noise_valid = 1'b0;
      glitch = 1'b1;
    end
  end

  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    drv_data  = b;
    drv_valid = 1'b1;
    @(negedge clk);
    drv_valid = 1'b0;
    drv_data  = 8'($urandom);
  endtask

  task automatic wait_ready(output bit ok);
    int t = 0;
    while (!tx_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    ok = tx_ready;
  endtask

  // Device side: clocks 10 bits out of the host, then drives the ack bit.
  task automatic bfm_frame(input logic ack, output logic [10:0] cap, output bit ok);
    int t = 0;
    cap = '1;
    ok  = 1'b0;
    while (!ps2_clk_oe && t < 200) begin @(negedge clk); t++; end
    if (!ps2_clk_oe) return;
    t = 0;
    while (ps2_clk_oe && t < INH + 50) begin @(negedge clk); t++; end
    if (ps2_clk_oe) return;
    repeat (10) @(negedge clk);
    cap[0] = ps2_data_in;
    repeat (HALF / 2) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      bfm_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      cap[i] = ps2_data_in;
      bfm_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
      if (i == 10) bfm_data = ack;
      repeat (HALF / 2) @(negedge clk);
    end
    bfm_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    bfm_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    bfm_data = 1'b1;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 00000", {ps2_clk_oe, ps2_data_oe, busy, done, err});
    end
    rstn = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_first_edge: got %b, want 1", tx_ready);
    end
  endtask

  task automatic test_frame(input logic [7:0] b, input logic ack, input string tag);
    logic [10:0] cap, exp;
    bit ok, rdy;
    int d0 = done_cnt, e0 = err_cnt, f0 = frame_cnt;
    exp = model_frame(b);
    send(b);
    bfm_frame(ack, cap, ok);
    wait_ready(rdy);
    vectors++;
    if (!ok) begin errors++; $display("FAIL %s_handshake: bfm saw no inhibit/release", tag); end
    vectors++;
    if (cap !== exp) begin errors++; $display("FAIL %s_bits: got %b, want %b", tag, cap, exp); end
    vectors++;
    if (last_oe_run !== INH) begin errors++; $display("FAIL %s_inhibit_len: got %0d, want %0d", tag, last_oe_run, INH); end
    vectors++;
    if (done_cnt - d0 !== (ack ? 0 : 1)) begin errors++; $display("FAIL %s_done: got %0d, want %0d", tag, done_cnt - d0, ack ? 0 : 1); end
    vectors++;
    if (err_cnt - e0 !== (ack ? 1 : 0)) begin errors++; $display("FAIL %s_err: got %0d, want %0d", tag, err_cnt - e0, ack ? 1 : 0); end
    vectors++;
    if (frame_cnt - f0 !== 1) begin errors++; $display("FAIL %s_frames: got %0d, want 1", tag, frame_cnt - f0); end
    vectors++;
    if (!rdy) begin errors++; $display("FAIL %s_ready: got %b, want 1", tag, tx_ready); end
  endtask

  task automatic test_timeout();
    int t = 0;
    int e0 = err_cnt, d0 = done_cnt;
    bit rdy;
    send(8'h5A);
    while (!ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    t = 0;
`ifdef PS2_TX_TIMEOUT_EN
    while (!err && t < TO + 1000) begin @(negedge clk); t++; end
    vectors++;
    if (t !== TO) begin errors++; $display("FAIL timeout_latency: got %0d, want %0d", t, TO); end
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL timeout_release: got %b, want 00", {ps2_clk_oe, ps2_data_oe}); end
    wait_ready(rdy);
    vectors++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      errors++; $display("FAIL timeout_pulses: err %0d done %0d, want 1 0", err_cnt - e0, done_cnt - d0);
    end
    vectors++;
    if (!rdy) begin errors++; $display("FAIL timeout_ready: got %b, want 1", tx_ready); end
`else
    repeat (TO + 1000) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL no_watchdog_busy: got %b, want 1", busy); end
    vectors++;
    if (err_cnt - e0 !== 0) begin errors++; $display("FAIL no_watchdog_err: got %0d, want 0", err_cnt - e0); end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL no_watchdog_recover: got %b, want 1", tx_ready); end
`endif
  endtask

  task automatic test_reset_midframe();
    int t = 0;
    send(8'h00);
    while (!ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    repeat (HALF / 2) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      bfm_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bfm_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    bfm_clk = 1'b0;
    repeat (FLT + 6) @(negedge clk);
    vectors++;
    if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL midframe_bit4: got oe %b, want 1", ps2_data_oe); end
    rstn = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, err} !== 5'b0) begin
      errors++; $display("FAIL midframe_reset: got %b, want 00000", {ps2_clk_oe, ps2_data_oe, busy, done, err});
    end
    rstn = 1'b1;
    bfm_clk = 1'b1;
    repeat (20) @(negedge clk);
    test_frame(8'h01, 1'b0, "after_reset");
  endtask

  task automatic test_busy_noise();
    logic [10:0] cap, exp;
    bit ok, rdy;
    logic [7:0] b = 8'($urandom);
    int f0 = frame_cnt, d0 = done_cnt;
    if (b == 8'hAA) b = 8'h3C;
    exp = model_frame(b);
    send(b);
    noise_left = 1500;
    noise_en = 1'b1;
    bfm_frame(1'b0, cap, ok);
    noise_en = 1'b0;
    wait_ready(rdy);
    repeat (300) @(negedge clk);
    vectors++;
    if (cap !== exp) begin errors++; $display("FAIL noise_bits: got %b, want %b", cap, exp); end
    vectors++;
    if (frame_cnt - f0 !== 1) begin errors++; $display("FAIL noise_frames: got %0d, want 1", frame_cnt - f0); end
    vectors++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL noise_done: got %0d, want 1", done_cnt - d0); end
    vectors++;
    if (!(ok && rdy && tx_ready)) begin errors++; $display("FAIL noise_ready: ok %b ready %b, want 1 1", ok, tx_ready); end
  endtask

  initial begin
    test_reset();
    test_frame(8'hF4, 1'b0, "f4_ack");
    test_frame(8'hED, 1'b1, "ed_nack");
    for (int i = 0; i < 3; i++) test_frame(8'($urandom), 1'($urandom_range(0, 1)), "random");
    test_timeout();
    test_reset_midframe();
    test_busy_noise();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000: clock-low hold time (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000: watchdog limit from REQ entry to ACK (20 ms at 100 MHz).
REQ-003 Parameter FILTER_CYCLES, default 8: consecutive equal samples required to accept a new PS/2 line level.
REQ-004 clk  in  1  system clock, single clock domain.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 tx_data  in  8  command byte to send to the device.
REQ-007 tx_valid  in  1  request; a byte is accepted on a clk edge where tx_valid and tx_ready are both 1.
REQ-008 tx_ready  out  1  high only in IDLE.
REQ-009 busy  out  1  high in every state except IDLE; the PS/2 receiver ignores frames while busy=1.
REQ-010 done  out  1  one-cycle pulse on successful ACK.
REQ-011 err  out  1  one-cycle pulse on NACK or timeout.
REQ-012 ps2_clk_in, ps2_data_in  in  1 each  raw PS/2 line levels (asynchronous).
REQ-013 ps2_clk_oe, ps2_data_oe  out  1 each  open-drain enables; 1 pulls the line low, 0 releases it.

Function
REQ-014 Each input line SHALL pass a 2-flop synchronizer, then a FILTER_CYCLES stability filter; a falling edge (fe) is a filtered 1->0 transition.
REQ-015 States SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK, and WAITIDLE.
REQ-016 IDLE: both oe=0 and tx_ready=1; on accept, latch tx_data, compute parity as XNOR of its bits (odd parity), and go to INHIBIT.
REQ-017 INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES cycles; in the final cycle assert ps2_data_oe=1 (start bit), then go to REQ.
REQ-018 REQ: ps2_clk_oe=0 and ps2_data_oe=1; clear the bit index and the watchdog; the first fe goes to SHIFT.
REQ-019 SHIFT: on fe k (k=1..8 counted from REQ), drive data bit k-1 (LSB first, ps2_data_oe = ~bit); fe 9 drives parity; fe 10 releases data (stop bit) and goes to ACK.
REQ-020 ACK: on the next fe, sample filtered data; 0 -> done pulse, 1 -> err pulse; then go to WAITIDLE.
REQ-021 WAITIDLE: both oe=0; once filtered clk and data are both 1, go to IDLE.
REQ-022 The bit index SHALL be 4 bits wide and SHALL saturate; no fe is counted outside REQ, SHIFT, or ACK.
REQ-023 tx_valid while busy SHALL be ignored; tx_data changes after accept SHALL NOT affect the frame in flight.
REQ-024 An fe occurring in the same cycle as the watchdog expiry SHALL resolve to timeout.
REQ-025 Outputs SHALL be registered; the oe change SHALL occur within FILTER_CYCLES+3 clk of the raw device clock edge.

Reset
REQ-026 Asserting rstn=0 at any time, including mid-frame, SHALL force IDLE with ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, and the filters preset to 1.
REQ-027 After reset release, tx_ready SHALL be 1 from the first clk edge.

Configuration
REQ-028 With PS2_TX_TIMEOUT_EN defined: a watchdog counts cycles in REQ, SHIFT, and ACK; at TIMEOUT_CYCLES it SHALL release both lines, pulse err, and go to WAITIDLE.
REQ-029 Without PS2_TX_TIMEOUT_EN: no watchdog logic; err SHALL come only from NACK, and TIMEOUT_CYCLES is unused.

Structure
REQ-030 Package ps2_pkg SHALL hold the tx state enum, the frame length constant (11), and a shared odd-parity function.
REQ-031 A sub-module ps2_line_filter (sync plus stability filter plus fe output) SHALL be instantiated twice, and is reusable by the receiver.

Verification (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=5000, FILTER_CYCLES=4, device BFM clock period 200 clk)
REQ-032 Send 0xF4 with BFM ACK=0 -> clk_oe high for 20 cycles; the BFM captures start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1; one done pulse; tx_ready returns to 1.
REQ-033 Send 0xED with BFM ACK=1 (NACK) -> parity 1 captured; exactly one err pulse and no done.
REQ-034 BFM never clocks, with macro defined -> err at 5000 cycles after REQ entry and both oe=0; without the macro, busy stays 1 and err stays 0.
REQ-035 Pulse rstn low during fe 5 of 0x00 -> next cycle both oe=0 and busy=0; a following send of 0x01 completes with parity 0.
REQ-036 Toggle tx_valid with 0xAA while busy, and inject 2-cycle glitches on ps2_clk_in -> no second frame, no extra bit shifted, and the captured byte equals the original.
